// File: rtl/fir_tdm.sv
// -----------------------------------------------------------------------------
// fir_tdm : time-multiplexed multichannel FIR filter.
//
// A single signed multiply-accumulate unit walks every tap of every channel
// (NUM_TAPS x NUM_CH cycles) for each accepted input frame. All channels share
// one runtime-loadable coefficient set. Results are full precision.
//
// Ports:
//   clk, resetn          system clock (rising edge), async active-low reset
//   in_valid / in_ready  input frame handshake; in_ready is high only in IDLE
//   in_data              packed signed samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   flush                clears all delay lines while IDLE (an accept wins)
//   coef_we/addr/wdata   coefficient write port, honoured only while IDLE
//   coef_drop            one-cycle pulse when a coefficient write is discarded
//   out_valid            one-cycle pulse when a whole frame of results is ready
//   out_data             packed signed results, channel c at [c*ACC_WIDTH +: ACC_WIDTH]
// -----------------------------------------------------------------------------
module fir_tdm #(
    parameter  int DATA_WIDTH = 16,
    parameter  int COEF_WIDTH = 16,
    parameter  int NUM_TAPS   = 16,
    parameter  int NUM_CH     = 2,
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS),
    localparam int TAP_W      = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    in_data,
    input  logic                            flush,
    input  logic                            coef_we,
    input  logic [TAP_W-1:0]                coef_addr,
    input  logic [COEF_WIDTH-1:0]           coef_wdata,
    output logic                            coef_drop,
    output logic                            out_valid,
    output logic [NUM_CH*ACC_WIDTH-1:0]     out_data
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W  = DATA_WIDTH + COEF_WIDTH;
    localparam logic [TAP_W:0]   NUM_TAPS_W = NUM_TAPS[TAP_W:0];
    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(NUM_TAPS - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

    typedef enum logic {S_IDLE, S_MAC} state_e;

    state_e                         state_q, state_d;
    logic [TAP_W-1:0]               tap_q, tap_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]   dly_q  [NUM_CH][NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]   dly_d  [NUM_CH][NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_d [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]    out_q  [NUM_CH];
    logic signed [ACC_WIDTH-1:0]    out_d  [NUM_CH];
    logic                           out_valid_q, out_valid_d;
    logic                           coef_drop_q, coef_drop_d;

    logic                           accept;
    logic                           addr_ok;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    acc_sum;

    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    // Widening by one bit lets non-power-of-2 depths reject out-of-range taps.
    assign addr_ok   = ({1'b0, coef_addr} < NUM_TAPS_W);

    // Signed sizing casts sign-extend before the multiply and the add.
    assign prod      = PROD_W'(coef_q[tap_q]) * PROD_W'(dly_q[ch_q][tap_q]);
    assign acc_sum   = acc_q + ACC_WIDTH'(prod);

    assign out_valid = out_valid_q;
    assign coef_drop = coef_drop_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            out_data[c*ACC_WIDTH +: ACC_WIDTH] = out_q[c];
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path leaves a
        // signal unassigned and no latch can be inferred.
        state_d     = state_q;
        tap_d       = tap_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        dly_d       = dly_q;
        coef_d      = coef_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        coef_drop_d = 1'b0;

        // Writes land in IDLE only, so a running frame never sees a torn set;
        // a write on the accepting edge is already visible to that frame.
        if (coef_we) begin
            if (state_q == S_IDLE && addr_ok) begin
                coef_d[coef_addr] = coef_wdata;
            end else begin
                coef_drop_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        for (int k = NUM_TAPS - 1; k > 0; k--) begin
                            dly_d[c][k] = dly_q[c][k-1];
                        end
                        dly_d[c][0] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
                    end
                    state_d = S_MAC;
                    tap_d   = '0;
                    ch_d    = '0;
                    acc_d   = '0;
                end else if (flush) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            dly_d[c][k] = '0;
                        end
                    end
                end
            end
            S_MAC: begin
                if (tap_q == LAST_TAP) begin
                    out_d[ch_q] = acc_sum;
                    acc_d       = '0;
                    tap_d       = '0;
                    ch_d        = ch_q + CH_W'(1);
                    if (ch_q == LAST_CH) begin
                        out_valid_d = 1'b1;
                        ch_d        = '0;
                        state_d     = S_IDLE;
                    end
                end else begin
                    acc_d = acc_sum;
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples the values
    // computed for this edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            ch_q        <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            coef_drop_q <= 1'b0;
            // NOTE: delay lines and coefficients are flop arrays that must come
            // out of reset as a cleared history and the identity impulse, so
            // they are reset here rather than left to a RAM.
            for (int c = 0; c < NUM_CH; c++) begin
                out_q[c] <= '0;
                for (int k = 0; k < NUM_TAPS; k++) begin
                    dly_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef_q[k] <= (k == 0) ? COEF_WIDTH'(1) : '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            coef_drop_q <= coef_drop_d;
            dly_q       <= dly_d;
            coef_q      <= coef_d;
            out_q       <= out_d;
        end
    end

endmodule
